// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side elastic buffer behind uart_rx with sticky overflow; optional error-frame drop via UART_RX_FIFO_DROP_ERR_EN
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                     uart_clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_frame_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_frame_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     ovf_clear,
  output logic [7:0]               drop_err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 1;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_err_cnt_q, drop_err_cnt_d;
  logic          pop, push, drop, store;
  logic [EW-1:0] head;
  assign in_ready    = !rst;
  assign empty       = level_q == '0;
  assign full        = level_q == LW'(DEPTH);
  assign almost_full = level_q >= LW'(AF_LEVEL);
  assign out_valid   = !empty;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign drop_err_cnt = drop_err_cnt_q;
  assign head          = mem_q[rd_ptr_q];
  assign out_data      = empty ? '0 : head[DATA_WIDTH-1:0];
  assign out_frame_err = empty ? 1'b0 : head[DATA_WIDTH];
  assign pop  = out_valid & out_ready;
  assign push = in_valid & in_ready & (!full | pop);
  assign drop = in_valid & full & !pop;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  // Errored frames complete the handshake but are only counted, never stored
  always_comb begin
    store          = push & !in_frame_err;
    drop_err_cnt_d = (in_valid & in_ready & in_frame_err & (drop_err_cnt_q != 8'hFF)) ? drop_err_cnt_q + 8'd1 : drop_err_cnt_q;
  end
`else
  // Errored frames are buffered like any other byte; the counter stays idle
  always_comb begin
    store          = push;
    drop_err_cnt_d = 8'd0;
  end
`endif
  // Next-state for pointers, occupancy and the sticky overflow flag (a drop beats a clear)
  always_comb begin
    wr_ptr_d   = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(store) - LW'(pop);
    overflow_d = drop | (overflow_q & !ovf_clear);
  end
  // Control state register; storage contents are deliberately left out of reset
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      drop_err_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      drop_err_cnt_q <= drop_err_cnt_d;
    end
  end
  // Entry write at the tail pointer
  always_ff @(posedge uart_clk) begin
    if (store) mem_q[wr_ptr_q] <= {in_frame_err, in_data};
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus with a queue-based reference model checked every cycle
module tb_uart_rx_fifo;
  logic       uart_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_frame_err = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_frame_err;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] level;
  logic       empty, full, almost_full, overflow;
  logic       ovf_clear = 1'b0;
  logic [7:0] drop_err_cnt;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12)) dut (
    .uart_clk(uart_clk), .rst(rst), .in_data(in_data), .in_frame_err(in_frame_err),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_frame_err(out_frame_err),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow), .ovf_clear(ovf_clear), .drop_err_cnt(drop_err_cnt)
  );

  always #5 uart_clk = ~uart_clk;

  logic [8:0] mq[$];
  bit         m_ovf = 0;
  int         m_cnt = 0;
  bit         en = 0;
  int         n_chk = 0, n_fail = 0;
  bit         p_en = 0;
  string      p_nm = "";
  int         p_lv, p_d, p_ov, p_fe, p_cnt;

  always @(posedge uart_clk) begin
    bit p, d;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      p = mq.size() != 0 && out_ready;
      d = in_valid && mq.size() == 16 && !p;
      if (p) void'(mq.pop_front());
`ifdef UART_RX_FIFO_DROP_ERR_EN
      if (in_valid && in_frame_err) m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
      else if (in_valid && !d) mq.push_back({in_frame_err, in_data});
`else
      if (in_valid && !d) mq.push_back({in_frame_err, in_data});
`endif
      m_ovf = d || (m_ovf && !ovf_clear);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge uart_clk) begin
    if (en) begin
      chk("in_ready", int'(in_ready), int'(!rst));
      chk("level", int'(level), mq.size());
      chk("out_valid", int'(out_valid), int'(mq.size() != 0));
      chk("out_data", int'(out_data), mq.size() != 0 ? int'(mq[0][7:0]) : 0);
      chk("out_frame_err", int'(out_frame_err), mq.size() != 0 ? int'(mq[0][8]) : 0);
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("full", int'(full), int'(mq.size() == 16));
      chk("almost_full", int'(almost_full), int'(mq.size() >= 12));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("drop_err_cnt", int'(drop_err_cnt), m_cnt);
    end
    if (p_en) begin
      chk({p_nm, " level"}, int'(level), p_lv);
      chk({p_nm, " out_data"}, int'(out_data), p_d);
      chk({p_nm, " overflow"}, int'(overflow), p_ov);
      chk({p_nm, " out_frame_err"}, int'(out_frame_err), p_fe);
      chk({p_nm, " drop_err_cnt"}, int'(drop_err_cnt), p_cnt);
    end
  end

  task automatic cyc(input bit v, input int d, input bit fe, input bit ordy, input bit clr);
    in_valid = v;
    in_data = 8'(d);
    in_frame_err = fe;
    out_ready = ordy;
    ovf_clear = clr;
    @(negedge uart_clk);
    #1;
  endtask

  task automatic pin(input string nm, input int lv, input int d, input int ov, input int fe, input int cnt);
    p_nm = nm;
    p_lv = lv;
    p_d = d;
    p_ov = ov;
    p_fe = fe;
    p_cnt = cnt;
    p_en = 1;
    cyc(0, 0, 0, 0, 0);
    p_en = 0;
  endtask

  initial begin
    rst = 1;
    cyc(0, 0, 0, 0, 0);
    en = 1;
    cyc(0, 0, 0, 0, 0);
    rst = 0;
    pin("reset", 0, 0, 0, 0, 0);
    cyc(1, 8'h41, 0, 0, 0);
    cyc(1, 8'h42, 0, 0, 0);
    cyc(1, 8'h43, 0, 0, 0);
    pin("order_fill", 3, 8'h41, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    pin("order_drain", 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, i, 0, 0, 0);
    pin("full", 16, 8'h00, 0, 0, 0);
    cyc(1, 8'hAA, 0, 0, 0);
    pin("drop", 16, 8'h00, 1, 0, 0);
    cyc(1, 8'hBB, 0, 0, 1);
    pin("drop_and_clear", 16, 8'h00, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    pin("clear", 16, 8'h00, 0, 0, 0);
    cyc(1, 8'h55, 0, 1, 0);
    pin("push_pop_full", 16, 8'h01, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0);
    pin("last_is_55", 1, 8'h55, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    pin("drained", 0, 0, 0, 0, 0);
    cyc(1, 8'h7E, 1, 0, 0);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    pin("err_drop", 0, 0, 0, 0, 1);
    for (int i = 0; i < 299; i++) cyc(1, i, 1, 0, 0);
    pin("err_sat", 0, 0, 0, 0, 255);
`else
    pin("err_store", 1, 8'h7E, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
`endif
    for (int i = 0; i < 5; i++) cyc(1, 8'h10 + i, 0, 0, 0);
    pin("pre_reset", 5, 8'h10, 0, 0,
`ifdef UART_RX_FIFO_DROP_ERR_EN
        255
`else
        0
`endif
    );
    rst = 1;
    cyc(0, 0, 0, 0, 0);
    rst = 0;
    pin("mid_reset", 0, 0, 0, 0, 0);
    cyc(1, 8'h33, 0, 0, 0);
    pin("after_reset", 1, 8'h33, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
